lcd_panel_model: RTL and testbench
==================================

# lcd_panel_model

Synthesizable responder for the 4-bit HD44780-style character-LCD bus that `lcd_driver` writes to. It watches `lcd_e`/`lcd_rs`/`lcd_w`/`data`, tracks the power-up 8-bit-to-4-bit handshake, and assembles nibble pairs into bytes. It decodes commands and keeps a 2x16 display buffer, exported as two 128-bit lines in the same packing the driver consumes. It sits on the bench side of the panel pins (loopback checking, or on-chip mirroring of what the panel shows).

## Interface
- `BUSY_CYCLES`, 2000: busy window after any non-clear byte and after each 8-bit-mode strobe
- `CLEAR_CYCLES`, 76000: busy window after clear (0x01)
- `clk` input 1: system clock, all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `lcd_rs` input 1: 0 command, 1 character data
- `lcd_w` input 1: 1 read request (unsupported), 0 write
- `lcd_e` input 1: enable; nibble accepted on falling edge
- `data` input 4: nibble bus
- `line1`, `line2` output 128: display rows; column c at bits [127-8c -: 8]
- `display_on` output 1: display-control D bit
- `two_line` output 1: function-set N bit
- `ready` output 1: interface is in 4-bit mode
- `busy` output 1: busy window active
- `cursor_addr` output 7: DDRAM address
- `byte_strobe` output 1: one-cycle pulse per assembled byte
- `byte_out` output 8, `byte_rs` output 1: last assembled byte and its RS
- `err_busy`, `err_read` output 1: sticky protocol-violation flags

## Operation
- `rst` drives every output and register to: lines all 0x20, `cursor_addr`=0, increment mode=1, all flags/strobes/`byte_out`/`byte_rs`=0, state INIT8, busy count 0.
- `lcd_e` passes through a 2-flop synchronizer and a falling-edge detector. `lcd_rs`, `lcd_w` and `data` are delayed by the same depth, so they are sampled aligned with the edge.
- Edge accepted only if `busy`=0. If `busy`=1, the edge is dropped, `err_busy` is set, and nibble phase is unchanged.
- An accepted edge with `lcd_w`=1 is dropped, sets `err_read`, and does not change phase.
- States:
  - INIT8: `data`=3 reloads busy with BUSY_CYCLES and stays in INIT8. `data`=2 reloads busy, sets `ready`, and moves to NIB_HI. Any other value is ignored.
  - NIB_HI: latch high nibble and RS, then go to NIB_LO.
  - NIB_LO: form byte = {hi, data}, pulse `byte_strobe`, execute, return to NIB_HI. RS comes from the high nibble.
- Byte execution with RS=0:
  - 0x01: all 32 cells become 0x20, addr=0, busy=CLEAR_CYCLES.
  - 0x02–0x03: addr=0.
  - 0x04–0x07: increment mode=bit1.
  - 0x08–0x0F: `display_on`=bit2.
  - 0x10–0x1F: no effect.
  - 0x20–0x3F: `two_line`=bit3.
  - 0x40–0x7F (CGRAM): no effect.
  - 0x80–0xFF: addr=byte[6:0].
- Every byte except clear reloads busy with BUSY_CYCLES.
- Byte execution with RS=1: if addr is 0x00–0x0F, write `line1` column addr. If addr is 0x40–0x4F, write `line2` column addr-0x40. Any other addr drops the write. Addr then moves by +1 or -1 modulo 128. Busy reloads.
- Busy counter decrements to 0 and saturates there; `busy` = (count != 0).

## Timing
- Let N be the first `clk` edge that samples `lcd_e` low after high. The edge is detected internally at N+2.
- Effects of the nibble are visible after edge N+3: state, `byte_strobe`, line update, flags, addr, and `busy` rise.
- `byte_strobe` is high for exactly one cycle. `byte_out` and `byte_rs` hold until the next byte.
- Reloading busy to K keeps `busy` high for exactly K cycles.
- Reset asserted mid-byte discards the pending high nibble and returns to INIT8 immediately (asynchronous).
- A clear overrides any simultaneous write; there is only one byte per edge, so no other collision is possible.
- `lcd_e` pulses shorter than 2 clk cycles are not guaranteed to be seen.

## Structure
- Package `lcd_pkg`:
  - state encoding INIT8/NIB_HI/NIB_LO
  - command-class boundaries 0x01/0x02/0x04/0x08/0x10/0x20/0x40/0x80
  - space 0x20
  - line bases 0x00/0x40 and line length 16
- One sub-module, `lcd_edge_sync`: 2-flop synchronizer on `lcd_e` plus matched delay for rs/w/data, outputting a one-cycle falling-edge pulse and aligned sampled signals.

## Test plan
Parameters for all scenarios: BUSY_CYCLES=4, CLEAR_CYCLES=8; ≥10 cycles between strobes.
- Init handshake: nibbles 3,3,3,2 with RS=0 -> `ready`=1 after the 4th edge, `byte_strobe` never pulses.
- Config sequence: after init, send 0x28, 0x06, 0x0C, 0x01 -> `two_line`=1, `display_on`=1, increment=1, lines all 0x20, `busy` high for 8 cycles after the clear.
- Writes: send 0x80 then RS=1 "HI" (0x48, 0x49) -> `line1`[127:112]=0x4849, `cursor_addr`=2. Then send 0xC0 and 'Z' -> `line2`[127:120]=0x5A.
- Dropped write: send 0x90 then 'A' -> both lines unchanged, `cursor_addr`=0x11.
- Busy violation: strobe 2 cycles after a byte completes -> edge dropped, `err_busy`=1, phase unchanged. The next legal nibble pair forms the correct byte.
- Reset mid-byte: send high nibble 4, assert `rst` -> lines 0x20, `ready`=0, state INIT8. A following 2 with no preceding 3s still enters 4-bit mode.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared encodings and constants for the HD44780-style panel model.
// Rev    : 1.0
// ============================================================================
package lcd_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_INIT8  = 2'd0,
        ST_NIB_HI = 2'd1,
        ST_NIB_LO = 2'd2
    } lcd_state_t;

    localparam logic [NIB_W-1:0] INIT_NIB_8 = 4'h3;
    localparam logic [NIB_W-1:0] INIT_NIB_4 = 4'h2;

    // Lower bound of each command class; a byte belongs to the highest bound it reaches.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0]   CHAR_SPACE = 8'h20;
    localparam logic [127:0] BLANK_LINE = {16{CHAR_SPACE}};

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE_LEN   = 7'd16;

    function automatic logic in_line(input logic [6:0] addr, input logic [6:0] base);
        logic [6:0] off;
        off = addr - base;
        return (off < LINE_LEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_panel_model_if.sv
`default_nettype none
// ============================================================================
// Module : lcd_panel_model_if
// Brief  : 4-bit character-LCD pin bus (driver side = master, panel = slave).
// Rev    : 1.0
// ============================================================================
interface lcd_panel_model_if;
    import lcd_pkg::*;

    logic             lcd_rs;
    logic             lcd_w;
    logic             lcd_e;
    logic [NIB_W-1:0] data;

    modport master (output lcd_rs, output lcd_w, output lcd_e, output data);
    modport slave  (input  lcd_rs, input  lcd_w, input  lcd_e, input  data);

endinterface
`default_nettype wire

// File: rtl/lcd_edge_sync.sv
`default_nettype none
// ============================================================================
// Module : lcd_edge_sync
// Brief  : Synchronises lcd_e, flags its falling edge, delays rs/w/data to match.
// Rev    : 1.0
// ============================================================================
module lcd_edge_sync
    import lcd_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_e,
    input  wire logic             i_rs,
    input  wire logic             i_w,
    input  wire logic [NIB_W-1:0] i_data,
    output logic                  o_fall,
    output logic                  o_rs,
    output logic                  o_w,
    output logic [NIB_W-1:0]      o_data
);

    logic             r_e_meta;
    logic             r_e_sync;
    logic             r_e_prev;
    logic             r_fall;
    logic [NIB_W+1:0] r_dly0;
    logic [NIB_W+1:0] r_dly1;
    logic [NIB_W+1:0] r_dly2;

    // Three-deep delay so the bus word leaves together with the registered edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_meta <= 1'b0;
            r_e_sync <= 1'b0;
            r_e_prev <= 1'b0;
            r_fall   <= 1'b0;
            r_dly0   <= '0;
            r_dly1   <= '0;
            r_dly2   <= '0;
        end else begin
            r_e_meta <= i_e;
            r_e_sync <= r_e_meta;
            r_e_prev <= r_e_sync;
            r_fall   <= r_e_prev & ~r_e_sync;
            r_dly0   <= {i_rs, i_w, i_data};
            r_dly1   <= r_dly0;
            r_dly2   <= r_dly1;
        end
    end

    assign o_fall = r_fall;
    assign o_rs   = r_dly2[NIB_W+1];
    assign o_w    = r_dly2[NIB_W];
    assign o_data = r_dly2[NIB_W-1:0];

endmodule
`default_nettype wire

// File: rtl/lcd_panel_model.sv
`default_nettype none
// ============================================================================
// Module : lcd_panel_model
// Brief  : 4-bit HD44780-style panel responder keeping a 2x16 display mirror.
// Rev    : 1.0
// ============================================================================
module lcd_panel_model
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lcd_panel_model_if.slave      bus,
    output logic [127:0]          line1,
    output logic [127:0]          line2,
    output logic                  display_on,
    output logic                  two_line,
    output logic                  ready,
    output logic                  busy,
    output logic [6:0]            cursor_addr,
    output logic                  byte_strobe,
    output logic [7:0]            byte_out,
    output logic                  byte_rs,
    output logic                  err_busy,
    output logic                  err_read
);

    localparam int c_MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_BUSY_LOAD  = c_CNT_W'(BUSY_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CLEAR_LOAD = c_CNT_W'(CLEAR_CYCLES);

    logic             w_fall;
    logic             w_rs;
    logic             w_w;
    logic [NIB_W-1:0] w_data;
    logic [7:0]       w_byte;
    logic [3:0]       w_col;
    logic [6:0]       w_addr_step;

    lcd_state_t         r_state;
    logic [NIB_W-1:0]   r_hi;
    logic               r_hi_rs;
    logic               r_incr;
    logic [c_CNT_W-1:0] r_busy_cnt;
    logic [127:0]       r_line1;
    logic [127:0]       r_line2;
    logic [6:0]         r_addr;
    logic               r_display_on;
    logic               r_two_line;
    logic               r_ready;
    logic               r_byte_strobe;
    logic [7:0]         r_byte_out;
    logic               r_byte_rs;
    logic               r_err_busy;
    logic               r_err_read;

    lcd_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .i_e    (bus.lcd_e),
        .i_rs   (bus.lcd_rs),
        .i_w    (bus.lcd_w),
        .i_data (bus.data),
        .o_fall (w_fall),
        .o_rs   (w_rs),
        .o_w    (w_w),
        .o_data (w_data)
    );

    assign w_byte      = {r_hi, w_data};
    assign w_col       = r_addr[3:0];
    assign w_addr_step = r_incr ? (r_addr + 7'd1) : (r_addr - 7'd1);
    assign busy        = (r_busy_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_INIT8;
            r_hi          <= '0;
            r_hi_rs       <= 1'b0;
            r_incr        <= 1'b1;
            r_busy_cnt    <= '0;
            r_line1       <= BLANK_LINE;
            r_line2       <= BLANK_LINE;
            r_addr        <= '0;
            r_display_on  <= 1'b0;
            r_two_line    <= 1'b0;
            r_ready       <= 1'b0;
            r_byte_strobe <= 1'b0;
            r_byte_out    <= '0;
            r_byte_rs     <= 1'b0;
            r_err_busy    <= 1'b0;
            r_err_read    <= 1'b0;
        end else begin
            r_byte_strobe <= 1'b0;
            if (busy) begin
                r_busy_cnt <= r_busy_cnt - 1'b1;
            end

            // Later assignments to r_busy_cnt below override the decrement.
            if (w_fall) begin
                if (busy) begin
                    r_err_busy <= 1'b1;
                end else if (w_w) begin
                    r_err_read <= 1'b1;
                end else begin
                    case (r_state)
                        ST_INIT8: begin
                            if (w_data == INIT_NIB_8) begin
                                r_busy_cnt <= c_BUSY_LOAD;
                            end else if (w_data == INIT_NIB_4) begin
                                r_busy_cnt <= c_BUSY_LOAD;
                                r_ready    <= 1'b1;
                                r_state    <= ST_NIB_HI;
                            end
                        end
                        ST_NIB_HI: begin
                            r_hi    <= w_data;
                            r_hi_rs <= w_rs;
                            r_state <= ST_NIB_LO;
                        end
                        ST_NIB_LO: begin
                            r_state       <= ST_NIB_HI;
                            r_byte_strobe <= 1'b1;
                            r_byte_out    <= w_byte;
                            r_byte_rs     <= r_hi_rs;
                            r_busy_cnt    <= c_BUSY_LOAD;
                            if (r_hi_rs) begin
                                if (in_line(r_addr, LINE1_BASE)) begin
                                    r_line1[127 - 8*int'(w_col) -: 8] <= w_byte;
                                end else if (in_line(r_addr, LINE2_BASE)) begin
                                    r_line2[127 - 8*int'(w_col) -: 8] <= w_byte;
                                end
                                r_addr <= w_addr_step;
                            end else if (w_byte == CMD_CLEAR) begin
                                r_line1    <= BLANK_LINE;
                                r_line2    <= BLANK_LINE;
                                r_addr     <= '0;
                                r_busy_cnt <= c_CLEAR_LOAD;
                            end else if (w_byte >= CMD_DDRAM) begin
                                r_addr <= w_byte[6:0];
                            end else if (w_byte >= CMD_CGRAM) begin
                                r_addr <= r_addr;
                            end else if (w_byte >= CMD_FUNC) begin
                                r_two_line <= w_byte[3];
                            end else if (w_byte >= CMD_SHIFT) begin
                                r_addr <= r_addr;
                            end else if (w_byte >= CMD_DISPLAY) begin
                                r_display_on <= w_byte[2];
                            end else if (w_byte >= CMD_ENTRY) begin
                                r_incr <= w_byte[1];
                            end else if (w_byte >= CMD_HOME) begin
                                r_addr <= '0;
                            end
                        end
                        default: r_state <= ST_INIT8;
                    endcase
                end
            end
        end
    end

    assign line1       = r_line1;
    assign line2       = r_line2;
    assign display_on  = r_display_on;
    assign two_line    = r_two_line;
    assign ready       = r_ready;
    assign cursor_addr = r_addr;
    assign byte_strobe = r_byte_strobe;
    assign byte_out    = r_byte_out;
    assign byte_rs     = r_byte_rs;
    assign err_busy    = r_err_busy;
    assign err_read    = r_err_read;

endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_model.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_panel_model
// Brief  : Directed self-checking bench for lcd_panel_model (BUSY=4, CLEAR=8).
// Rev    : 1.0
// ============================================================================
module tb_lcd_panel_model;

    localparam logic [127:0] c_BLANK = {16{8'h20}};

    logic         clk;
    logic         rst;
    logic [127:0] line1;
    logic [127:0] line2;
    logic         display_on;
    logic         two_line;
    logic         ready;
    logic         busy;
    logic [6:0]   cursor_addr;
    logic         byte_strobe;
    logic [7:0]   byte_out;
    logic         byte_rs;
    logic         err_busy;
    logic         err_read;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int bcnt;
    int s0;
    logic [127:0] exp_l1;
    logic [127:0] exp_l2;

    lcd_panel_model_if bus ();

    lcd_panel_model #(
        .BUSY_CYCLES  (4),
        .CLEAR_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .line1       (line1),
        .line2       (line2),
        .display_on  (display_on),
        .two_line    (two_line),
        .ready       (ready),
        .busy        (busy),
        .cursor_addr (cursor_addr),
        .byte_strobe (byte_strobe),
        .byte_out    (byte_out),
        .byte_rs     (byte_rs),
        .err_busy    (err_busy),
        .err_read    (err_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (byte_strobe === 1'b1) strobe_cnt++;

    // Strobe one nibble, then idle 20 cycles while counting busy cycles.
    task automatic send_nibble(input logic rs, input logic w, input logic [3:0] d, output int bc);
        bc = 0;
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_w = w; bus.data = d; bus.lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, output int bc);
        int tmp;
        send_nibble(rs, 1'b0, b[7:4], tmp);
        send_nibble(rs, 1'b0, b[3:0], bc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_w = 1'b0; bus.data = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (line1 !== c_BLANK || line2 !== c_BLANK) begin errors++; $display("FAIL reset_lines: got %h/%h expected all 20", line1, line2); end
        checks++; if (cursor_addr !== 7'h00 || ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got addr=%h ready=%b busy=%b expected 00/0/0", cursor_addr, ready, busy); end
        checks++; if ({display_on, two_line, byte_strobe, byte_rs, err_busy, err_read} !== 6'b0 || byte_out !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b out=%h expected 000000 out=00", {display_on, two_line, byte_strobe, byte_rs, err_busy, err_read}, byte_out); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_init();
        for (int i = 0; i < 3; i++) begin
            send_nibble(1'b0, 1'b0, 4'h3, bcnt);
            checks++; if (ready !== 1'b0 || bcnt != 4) begin errors++; $display("FAIL init_3_%0d: got ready=%b busy_cyc=%0d expected 0/4", i, ready, bcnt); end
        end
        send_nibble(1'b0, 1'b0, 4'h2, bcnt);
        checks++; if (ready !== 1'b1 || bcnt != 4) begin errors++; $display("FAIL init_2: got ready=%b busy_cyc=%0d expected 1/4", ready, bcnt); end
        checks++; if (strobe_cnt != 0) begin errors++; $display("FAIL init_no_strobe: got %0d expected 0", strobe_cnt); end
    endtask

    task automatic test_config();
        send_byte(1'b0, 8'h28, bcnt);
        checks++; if (two_line !== 1'b1 || byte_out !== 8'h28 || byte_rs !== 1'b0 || strobe_cnt != 1 || bcnt != 4) begin errors++; $display("FAIL cfg_func: got N=%b out=%h rs=%b strobes=%0d busy_cyc=%0d expected 1/28/0/1/4", two_line, byte_out, byte_rs, strobe_cnt, bcnt); end
        send_byte(1'b0, 8'h06, bcnt);
        send_byte(1'b0, 8'h0C, bcnt);
        checks++; if (display_on !== 1'b1 || strobe_cnt != 3) begin errors++; $display("FAIL cfg_disp: got D=%b strobes=%0d expected 1/3", display_on, strobe_cnt); end
        send_byte(1'b0, 8'h01, bcnt);
        checks++; if (bcnt != 8 || line1 !== c_BLANK || line2 !== c_BLANK || cursor_addr !== 7'h00) begin errors++; $display("FAIL cfg_clear: got busy_cyc=%0d addr=%h expected 8/00 and blank lines", bcnt, cursor_addr); end
    endtask

    task automatic test_writes();
        send_byte(1'b0, 8'h80, bcnt);
        send_byte(1'b1, 8'h48, bcnt);
        send_byte(1'b1, 8'h49, bcnt);
        checks++; if (line1[127:112] !== 16'h4849 || cursor_addr !== 7'h02 || byte_rs !== 1'b1) begin errors++; $display("FAIL wr_hi: got %h addr=%h rs=%b expected 4849/02/1", line1[127:112], cursor_addr, byte_rs); end
        send_byte(1'b0, 8'hC0, bcnt);
        send_byte(1'b1, 8'h5A, bcnt);
        exp_l2 = {8'h5A, {15{8'h20}}};
        checks++; if (line2 !== exp_l2 || cursor_addr !== 7'h41) begin errors++; $display("FAIL wr_z: got %h addr=%h expected %h/41", line2, cursor_addr, exp_l2); end
        // Decrement mode: write at column 0 and wrap to 0x7F.
        send_byte(1'b0, 8'h04, bcnt);
        send_byte(1'b0, 8'h80, bcnt);
        send_byte(1'b1, 8'h42, bcnt);
        exp_l1 = {8'h42, 8'h49, {14{8'h20}}};
        checks++; if (line1 !== exp_l1 || cursor_addr !== 7'h7F) begin errors++; $display("FAIL wr_dec: got %h addr=%h expected %h/7f", line1, cursor_addr, exp_l1); end
        send_byte(1'b0, 8'h06, bcnt);
    endtask

    task automatic test_dropped();
        send_byte(1'b0, 8'h90, bcnt);
        send_byte(1'b1, 8'h41, bcnt);
        checks++; if (line1 !== exp_l1 || line2 !== exp_l2 || cursor_addr !== 7'h11) begin errors++; $display("FAIL drop_wr: got l1=%h l2=%h addr=%h expected unchanged/11", line1, line2, cursor_addr); end
    endtask

    task automatic test_read();
        s0 = strobe_cnt;
        send_nibble(1'b0, 1'b1, 4'hF, bcnt);
        checks++; if (err_read !== 1'b1 || bcnt != 0) begin errors++; $display("FAIL rd_flag: got err_read=%b busy_cyc=%0d expected 1/0", err_read, bcnt); end
        send_byte(1'b0, 8'h08, bcnt);
        checks++; if (byte_out !== 8'h08 || display_on !== 1'b0 || strobe_cnt != s0 + 1) begin errors++; $display("FAIL rd_phase: got out=%h D=%b strobes=%0d expected 08/0/%0d", byte_out, display_on, strobe_cnt, s0 + 1); end
    endtask

    task automatic test_busy_violation();
        s0 = strobe_cnt;
        checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL busy_pre: got err_busy=%b expected 0", err_busy); end
        send_nibble(1'b0, 1'b0, 4'h0, bcnt);
        @(negedge clk);
        bus.lcd_rs = 1'b0; bus.data = 4'hE; bus.lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        @(negedge clk);
        bus.data = 4'hF; bus.lcd_e = 1'b1;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (err_busy !== 1'b1 || byte_out !== 8'h0E || strobe_cnt != s0 + 1) begin errors++; $display("FAIL busy_drop: got err_busy=%b out=%h strobes=%0d expected 1/0e/%0d", err_busy, byte_out, strobe_cnt, s0 + 1); end
        send_byte(1'b0, 8'h0C, bcnt);
        checks++; if (byte_out !== 8'h0C || display_on !== 1'b1 || strobe_cnt != s0 + 2) begin errors++; $display("FAIL busy_next: got out=%h D=%b strobes=%0d expected 0c/1/%0d", byte_out, display_on, strobe_cnt, s0 + 2); end
    endtask

    task automatic test_reset_mid_byte();
        send_nibble(1'b1, 1'b0, 4'h4, bcnt);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b0 || line1 !== c_BLANK || line2 !== c_BLANK || err_busy !== 1'b0) begin errors++; $display("FAIL mid_rst: got ready=%b l1=%h err_busy=%b expected 0/blank/0", ready, line1, err_busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_nibble(1'b0, 1'b0, 4'h2, bcnt);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready); end
        send_byte(1'b0, 8'h80, bcnt);
        send_byte(1'b1, 8'h4B, bcnt);
        checks++; if (byte_out !== 8'h4B || byte_rs !== 1'b1 || line1[127:120] !== 8'h4B || cursor_addr !== 7'h01) begin errors++; $display("FAIL mid_write: got out=%h rs=%b col0=%h addr=%h expected 4b/1/4b/01", byte_out, byte_rs, line1[127:120], cursor_addr); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_init();
        test_config();
        test_writes();
        test_dropped();
        test_read();
        test_busy_violation();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
